// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the response state type and the byte-lane helper
// for the wait-state data memory.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} resp_state_t;

  // Little-endian byte enables for a transfer of the given size at addr[1:0].
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] size,
                                               input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << lane;
      HSIZE_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_wait_sram_if.sv
// AHB-Lite bus bundle between a manager and the wait-state data memory.
interface ahb_wait_sram_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_resp_fsm.sv
// Response sequencer: stretches OKAY data phases by WAIT_STATES cycles and
// produces the two-cycle ERROR response.
module ahb_resp_fsm
  import ahb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic accept,
  input  logic accept_err,
  output logic HREADYOUT,
  output logic HRESP
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  resp_state_t state;
  resp_state_t next_state;
  logic [3:0]  wait_cnt;
  logic        ready_phase;

  assign ready_phase = (state == IDLE) || (state == ERR2);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (ready_phase && accept && !accept_err)
        wait_cnt <= WAIT_LOAD;
      else if (state == WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // New transfers are only taken in a cycle that completes the previous one.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, ERR2: begin
        if (accept && accept_err)
          next_state = ERR1;
        else if (accept && WAIT_STATES > 0)
          next_state = WAIT;
        else
          next_state = IDLE;
      end
      WAIT:    next_state = (wait_cnt == 4'd0) ? IDLE : WAIT;
      ERR1:    next_state = ERR2;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = ready_phase;
    HRESP     = (state == ERR1) || (state == ERR2);
  end

endmodule

// File: rtl/ahb_wait_sram.sv
// AHB-Lite data memory with programmable wait states and ERROR responses for
// out-of-range, oversized or misaligned transfers.
module ahb_wait_sram
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 32768,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            HCLK,
  input logic            HRESET,
  ahb_wait_sram_if.slave bus
);

  localparam int unsigned WORDS = MEM_DEPTH / 4;
  localparam int          AW    = $clog2(MEM_DEPTH);

  logic [31:0]   offset;
  logic          accept;
  logic          addr_err;
  logic          d_valid;
  logic          d_write;
  logic          d_err;
  logic [2:0]    d_size;
  logic [1:0]    d_lane;
  logic [AW-3:0] d_word;
  logic [3:0]    lane_mask;
  logic          commit;
  logic [31:0]   mem [WORDS];

  assign offset = bus.HADDR - BASE_ADDR;
  assign accept = bus.HSEL && bus.HREADY &&
                  (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

  // An address below BASE_ADDR wraps the offset high and lands in the range error.
  always_comb begin
    addr_err = (offset >= MEM_DEPTH) || (bus.HSIZE > HSIZE_WORD) ||
               (bus.HSIZE == HSIZE_HALF && bus.HADDR[0]) ||
               (bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00);
  end

  ahb_resp_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_resp_fsm (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .accept    (accept),
    .accept_err(addr_err),
    .HREADYOUT (bus.HREADYOUT),
    .HRESP     (bus.HRESP)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_err   <= 1'b0;
      d_size  <= 3'b000;
      d_lane  <= 2'b00;
      d_word  <= '0;
    end else if (bus.HREADYOUT) begin
      d_valid <= accept;
      if (accept) begin
        d_write <= bus.HWRITE;
        d_err   <= addr_err;
        d_size  <= bus.HSIZE;
        d_lane  <= offset[1:0];
        d_word  <= offset[AW-1:2];
      end
    end
  end

  assign lane_mask = ahb_lane_mask(d_size, d_lane);
  assign commit    = d_valid && d_write && !d_err && bus.HREADYOUT;

  // Storage is deliberately left unreset; a reset edge only blocks the commit.
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i])
          mem[d_word][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HRDATA = (d_valid && !d_write && !d_err && bus.HREADYOUT) ? mem[d_word] : 32'h0;

endmodule

// File: tb/tb_ahb_wait_sram.sv
// Directed bench for the wait-state AHB memory: one instance with two wait
// states and one with zero, sharing clock and reset.
module tb_ahb_wait_sram;

  logic HCLK;
  logic HRESET;
  int   compared;
  int   mismatched;

  ahb_wait_sram_if b2 ();
  ahb_wait_sram_if b0 ();

  assign b2.HREADY = b2.HREADYOUT;
  assign b0.HREADY = b0.HREADYOUT;

  ahb_wait_sram #(.MEM_DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(b2.slave)
  );

  ahb_wait_sram #(.MEM_DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(b0.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single non-pipelined transfer on the two-wait-state instance, called at a negedge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int lowCycles, output logic respLow, output logic respDone);
    int n;
    b2.HSEL = 1'b1; b2.HTRANS = 2'b10; b2.HADDR = addr; b2.HWRITE = wr; b2.HSIZE = size;
    @(negedge HCLK);
    b2.HSEL = 1'b0; b2.HTRANS = 2'b00; b2.HWDATA = wdata;
    lowCycles = 0; respLow = 1'b0; n = 0;
    while (b2.HREADYOUT !== 1'b1 && n < 20) begin
      lowCycles++;
      respLow = respLow | b2.HRESP;
      @(negedge HCLK);
      n++;
    end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("[TB] FAIL xfer_timeout addr=%h: HREADYOUT never returned to 1", addr);
    end
    rdata = b2.HRDATA;
    respDone = b2.HRESP;
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    compared++; if (b2.HREADYOUT !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hreadyout got=%b exp=1", b2.HREADYOUT); end
    compared++; if (b2.HRESP !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hresp got=%b exp=0", b2.HRESP); end
    compared++; if (b2.HRDATA !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hrdata got=%h exp=0", b2.HRDATA); end
    compared++; if (b0.HREADYOUT !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_hreadyout0 got=%b exp=1", b0.HREADYOUT); end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_wait_word();
    logic [31:0] rd; int low; logic rl, rs;
    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, low, rl, rs);
    compared++; if (low !== 2) begin mismatched++; $display("[TB] FAIL wr_wait_cycles got=%0d exp=2", low); end
    compared++; if (rs !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_resp got=%b exp=0", rs); end
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (low !== 2) begin mismatched++; $display("[TB] FAIL rd_wait_cycles got=%0d exp=2", low); end
    compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL rd_word got=%h exp=deadbeef", rd); end
    compared++; if (rl !== 1'b0 || rs !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_resp got=%b%b exp=00", rl, rs); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int low; logic rl, rs;
    xfer(1'b1, 32'h20, 3'b010, 32'hAABBCCDD, rd, low, rl, rs);
    xfer(1'b1, 32'h21, 3'b000, 32'hEEEE11EE, rd, low, rl, rs);
    xfer(1'b1, 32'h23, 3'b000, 32'h22EEEEEE, rd, low, rl, rs);
    xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (rd !== 32'h22BB11DD) begin mismatched++; $display("[TB] FAIL byte_lanes got=%h exp=22bb11dd", rd); end
    xfer(1'b1, 32'h24, 3'b010, 32'h01020304, rd, low, rl, rs);
    xfer(1'b1, 32'h26, 3'b001, 32'h9876EEEE, rd, low, rl, rs);
    xfer(1'b0, 32'h24, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (rd !== 32'h98760304) begin mismatched++; $display("[TB] FAIL half_lanes got=%h exp=98760304", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; int low; logic rl, rs;
    xfer(1'b1, 32'h30, 3'b010, 32'h12345678, rd, low, rl, rs);
    xfer(1'b0, 32'h31, 3'b001, 32'h0, rd, low, rl, rs);
    compared++; if (low !== 1 || rl !== 1'b1) begin mismatched++; $display("[TB] FAIL err_misalign_err1 got low=%0d resp=%b exp low=1 resp=1", low, rl); end
    compared++; if (rs !== 1'b1) begin mismatched++; $display("[TB] FAIL err_misalign_err2 got=%b exp=1", rs); end
    compared++; if (rd !== 32'h0) begin mismatched++; $display("[TB] FAIL err_rdata got=%h exp=0", rd); end
    xfer(1'b1, 32'h31, 3'b001, 32'hFFFFFFFF, rd, low, rl, rs);
    compared++; if (low !== 1 || rs !== 1'b1) begin mismatched++; $display("[TB] FAIL err_write_resp got low=%0d resp=%b exp low=1 resp=1", low, rs); end
    xfer(1'b0, 32'h30, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (rd !== 32'h12345678) begin mismatched++; $display("[TB] FAIL err_mem_unchanged got=%h exp=12345678", rd); end
    xfer(1'b0, 32'h100, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (low !== 1 || rl !== 1'b1 || rs !== 1'b1) begin mismatched++; $display("[TB] FAIL err_range got low=%0d resp=%b%b exp low=1 resp=11", low, rl, rs); end
    xfer(1'b0, 32'h0, 3'b011, 32'h0, rd, low, rl, rs);
    compared++; if (low !== 1 || rl !== 1'b1 || rs !== 1'b1) begin mismatched++; $display("[TB] FAIL err_size got low=%0d resp=%b%b exp low=1 resp=11", low, rl, rs); end
  endtask

  task automatic test_back_to_back();
    b0.HSEL = 1'b1; b0.HTRANS = 2'b10; b0.HADDR = 32'h40; b0.HWRITE = 1'b1; b0.HSIZE = 3'b010;
    @(negedge HCLK);
    compared++; if (b0.HREADYOUT !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_wr_ready got=%b exp=1", b0.HREADYOUT); end
    compared++; if (b0.HRDATA !== 32'h0) begin mismatched++; $display("[TB] FAIL b2b_wr_rdata got=%h exp=0", b0.HRDATA); end
    b0.HWDATA = 32'h5; b0.HWRITE = 1'b0;
    @(negedge HCLK);
    b0.HSEL = 1'b0; b0.HTRANS = 2'b00;
    compared++; if (b0.HREADYOUT !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_rd_ready got=%b exp=1", b0.HREADYOUT); end
    compared++; if (b0.HRDATA !== 32'h5) begin mismatched++; $display("[TB] FAIL b2b_rd_data got=%h exp=5", b0.HRDATA); end
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; int low; logic rl, rs;
    xfer(1'b1, 32'h50, 3'b010, 32'h01010101, rd, low, rl, rs);
    b2.HSEL = 1'b1; b2.HTRANS = 2'b10; b2.HADDR = 32'h50; b2.HWRITE = 1'b1; b2.HSIZE = 3'b010;
    @(negedge HCLK);
    b2.HSEL = 1'b0; b2.HTRANS = 2'b00; b2.HWDATA = 32'h77;
    compared++; if (b2.HREADYOUT !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_in_wait got=%b exp=0", b2.HREADYOUT); end
    HRESET = 1'b1;
    @(negedge HCLK);
    compared++; if (b2.HREADYOUT !== 1'b1 || b2.HRESP !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_outputs got rdy=%b resp=%b exp rdy=1 resp=0", b2.HREADYOUT, b2.HRESP); end
    compared++; if (b2.HRDATA !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mid_rdata got=%h exp=0", b2.HRDATA); end
    HRESET = 1'b0;
    @(negedge HCLK);
    xfer(1'b0, 32'h50, 3'b010, 32'h0, rd, low, rl, rs);
    compared++; if (rd !== 32'h01010101) begin mismatched++; $display("[TB] FAIL rst_mid_old_value got=%h exp=01010101", rd); end
    compared++; if (low !== 2) begin mismatched++; $display("[TB] FAIL rst_mid_read_wait got=%0d exp=2", low); end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    HRESET = 1'b1;
    b2.HSEL = 1'b0; b2.HADDR = 32'h0; b2.HTRANS = 2'b00; b2.HWRITE = 1'b0; b2.HSIZE = 3'b000; b2.HWDATA = 32'h0;
    b0.HSEL = 1'b0; b0.HADDR = 32'h0; b0.HTRANS = 2'b00; b0.HWRITE = 1'b0; b0.HSIZE = 3'b000; b0.HWDATA = 32'h0;
    test_reset();
    test_wait_word();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
